zoom_controller: RTL and testbench

- Consumes the single-cycle command pulses and level signals produced by the HPS command interface.
- Maintains the current zoom level and, on each accepted command, regenerates a 160x120 output frame.
- Regeneration reads the source image RAM (read port) and writes the frame buffer, using nearest-neighbour replication for zoom-in and decimation for zoom-out.
- Reports completion with a one-cycle controller_done pulse plus the resulting level.

---
 rtl/zoom_controller.sv | 158 +++++++++++++++
 tb/tb_zoom_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_controller.sv
// Zoom controller: on each accepted command, rescans a full output frame from the
// source image RAM into the frame buffer using a centred nearest-neighbour zoom map.
module zoom_controller #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int ADDR_W      = 15,
  parameter int PIX_W       = 8,
  parameter int MAX_LEVEL   = 4,
  parameter int UNITY_LEVEL = 2
) (
  input  logic              CLOCK_50,
  input  logic              POWER_ON_RESET,
  input  logic              cmd_reset_pulse,
  input  logic              cmd_zoom_in_pulse,
  input  logic              cmd_zoom_out_pulse,
  input  logic              cmd_return_pulse,
  input  logic [1:0]        cmd_algorithm_select,
  input  logic              cmd_multiple_sw_error,
  input  logic              cmd_no_sw_error,
  output logic [ADDR_W-1:0] src_rdaddress,
  input  logic [PIX_W-1:0]  src_q,
  output logic [ADDR_W-1:0] fb_wraddress,
  output logic [PIX_W-1:0]  fb_data,
  output logic              fb_wren,
  output logic              controller_done,
  output logic [2:0]        controller_zoom_level,
  output logic              busy,
  output logic [1:0]        algo_latched,
  output logic [1:0]        state_dbg
);

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);
  // Signed coordinate width with headroom for the widest zoom-out excursion.
  localparam int C_W = X_W + 4;
  localparam logic signed [C_W-1:0] CX    = C_W'(IMG_W / 2);
  localparam logic signed [C_W-1:0] CY    = C_W'(IMG_H / 2);
  localparam logic signed [C_W-1:0] X_LIM = C_W'(IMG_W);
  localparam logic signed [C_W-1:0] Y_LIM = C_W'(IMG_H);
  localparam logic [2:0]            UNITY = 3'(UNITY_LEVEL);
  localparam logic [2:0]            TOP   = 3'(MAX_LEVEL);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t              state, state_next;
  logic [2:0]          level, level_next;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [1:0]          algo;
  logic                start_scan, last_pix;
  logic                wr_valid, wr_oor;
  logic [ADDR_W-1:0]   wr_addr;
  logic signed [C_W-1:0] dx, dy, sx, sy;
  logic [2:0]          shift;
  logic                in_range;
  logic [ADDR_W-1:0]   src_addr, pix_addr;

  // Command strobes are single-cycle and have no back-pressure: zoom/return are
  // taken only in IDLE (busy low), while cmd_reset_pulse is taken in any state.
  always_comb begin
    state_next = state;
    level_next = level;
    start_scan = 1'b0;
    last_pix   = (x == X_W'(IMG_W - 1)) && (y == Y_W'(IMG_H - 1));
    case (state)
      IDLE: begin
        if (cmd_return_pulse || cmd_zoom_in_pulse || cmd_zoom_out_pulse) begin
          if (cmd_multiple_sw_error || cmd_no_sw_error) begin
            state_next = DONE;
          end else if (cmd_return_pulse) begin
            level_next = UNITY;
            start_scan = 1'b1;
          end else if (cmd_zoom_in_pulse) begin
            if (level == TOP) state_next = DONE;
            else begin
              level_next = level + 3'd1;
              start_scan = 1'b1;
            end
          end else if (level == 3'd0) begin
            state_next = DONE;
          end else begin
            level_next = level - 3'd1;
            start_scan = 1'b1;
          end
        end
      end
      SCAN:    if (last_pix) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (cmd_reset_pulse) begin
      level_next = UNITY;
      start_scan = 1'b1;
    end
    if (start_scan) state_next = SCAN;
  end

  // Map the output pixel back into the source around the image centre.
  always_comb begin
    dx = $signed(C_W'(x)) - CX;
    dy = $signed(C_W'(y)) - CY;
    if (level >= UNITY) begin
      shift = level - UNITY;
      sx    = CX + (dx >>> shift);
      sy    = CY + (dy >>> shift);
    end else begin
      shift = UNITY - level;
      sx    = CX + (dx <<< shift);
      sy    = CY + (dy <<< shift);
    end
    in_range = !sx[C_W-1] && (sx < X_LIM) && !sy[C_W-1] && (sy < Y_LIM);
    src_addr = ADDR_W'(sy[C_W-2:0]) * ADDR_W'(IMG_W) + ADDR_W'(sx[C_W-2:0]);
    pix_addr = ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
  end

  always_ff @(posedge CLOCK_50) begin
    if (POWER_ON_RESET) begin
      state    <= IDLE;
      level    <= UNITY;
      x        <= '0;
      y        <= '0;
      algo     <= '0;
      wr_valid <= 1'b0;
      wr_oor   <= 1'b0;
      wr_addr  <= '0;
    end else begin
      state    <= state_next;
      level    <= level_next;
      wr_valid <= (state == SCAN);
      wr_oor   <= !in_range;
      if (state == SCAN) wr_addr <= pix_addr;
      if (start_scan) begin
        x    <= '0;
        y    <= '0;
        algo <= cmd_algorithm_select;
      end else if (state == SCAN) begin
        if (x == X_W'(IMG_W - 1)) begin
          x <= '0;
          y <= y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end
    end
  end

  assign src_rdaddress         = ((state == SCAN) && in_range) ? src_addr : '0;
  assign fb_wren               = wr_valid;
  assign fb_wraddress          = wr_addr;
  assign fb_data               = (wr_valid && !wr_oor) ? src_q : '0;
  assign controller_done       = (state == DONE);
  assign controller_zoom_level = level;
  assign busy                  = (state == SCAN) || (state == DRAIN);
  assign algo_latched          = algo;
  assign state_dbg             = state;

endmodule

// File: tb/tb_zoom_controller.sv
// Bench for zoom_controller: source RAM and frame-buffer models, a per-cycle
// reference of the command/zoom rules, and directed command sequences.
module tb_zoom_controller;

  localparam int IMG_W  = 160;
  localparam int IMG_H  = 120;
  localparam int ADDR_W = 15;
  localparam int PIX_W  = 8;
  localparam int NPIX   = IMG_W * IMG_H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              POWER_ON_RESET = 1'b1;
  logic              cmd_reset_pulse = 1'b0, cmd_zoom_in_pulse = 1'b0;
  logic              cmd_zoom_out_pulse = 1'b0, cmd_return_pulse = 1'b0;
  logic [1:0]        cmd_algorithm_select = 2'd0;
  logic              cmd_multiple_sw_error = 1'b0, cmd_no_sw_error = 1'b0;
  logic [ADDR_W-1:0] src_rdaddress, fb_wraddress;
  logic [PIX_W-1:0]  src_q = '0;
  logic [PIX_W-1:0]  fb_data;
  logic              fb_wren, controller_done, busy;
  logic [2:0]        controller_zoom_level;
  logic [1:0]        algo_latched, state_dbg;

  zoom_controller dut (
    .CLOCK_50(clk),
    .POWER_ON_RESET(POWER_ON_RESET),
    .cmd_reset_pulse(cmd_reset_pulse),
    .cmd_zoom_in_pulse(cmd_zoom_in_pulse),
    .cmd_zoom_out_pulse(cmd_zoom_out_pulse),
    .cmd_return_pulse(cmd_return_pulse),
    .cmd_algorithm_select(cmd_algorithm_select),
    .cmd_multiple_sw_error(cmd_multiple_sw_error),
    .cmd_no_sw_error(cmd_no_sw_error),
    .src_rdaddress(src_rdaddress),
    .src_q(src_q),
    .fb_wraddress(fb_wraddress),
    .fb_data(fb_data),
    .fb_wren(fb_wren),
    .controller_done(controller_done),
    .controller_zoom_level(controller_zoom_level),
    .busy(busy),
    .algo_latched(algo_latched),
    .state_dbg(state_dbg)
  );

  // ---------------- memories ----------------
  logic [PIX_W-1:0] mem [NPIX];
  logic [PIX_W-1:0] fb  [NPIX];

  always @(posedge clk) begin
    src_q <= mem[src_rdaddress];
    if (fb_wren) fb[fb_wraddress] <= fb_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int wren_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (fb_wren) wren_cnt++;
    if (controller_done) done_cnt++;
  end

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Applied state: scan start cycle, done cycle, level and latched algorithm.
  int         m_scan = -1, m_done = -1, m_lvl = 2;
  logic [1:0] m_algo = 2'd0;
  // Pending change, effective from cycle p_at.
  bit         p_valid = 0, p_kill = 0;
  int         p_at, p_scan, p_done, p_lvl;
  logic [1:0] p_algo;
  int         last_a;
  bit         cmp_en = 0;

  function automatic void map_pix(input int idx, input int lvl, output int src, output bit oor);
    int x, y, dx, dy, sx, sy;
    x  = idx % IMG_W;
    y  = idx / IMG_W;
    dx = x - IMG_W / 2;
    dy = y - IMG_H / 2;
    if (lvl >= 2) begin
      sx = IMG_W / 2 + (dx >>> (lvl - 2));
      sy = IMG_H / 2 + (dy >>> (lvl - 2));
    end else begin
      sx = IMG_W / 2 + dx * (1 << (2 - lvl));
      sy = IMG_H / 2 + dy * (1 << (2 - lvl));
    end
    oor = (sx < 0) || (sx >= IMG_W) || (sy < 0) || (sy >= IMG_H);
    src = oor ? 0 : sy * IMG_W + sx;
  endfunction

  function automatic bit model_busy(input int t);
    return (m_scan >= 0) && (t >= m_scan) && (t <= m_scan + NPIX);
  endfunction

  bit               prev_v = 0, iss_v, iss_oor;
  int               prev_idx = 0, iss_idx, iss_src;
  logic [PIX_W-1:0] prev_data = '0;
  logic [63:0]      exp_v, act_v;

  always @(negedge clk) begin
    if (p_valid && cyc >= p_at) begin
      m_scan = p_scan; m_done = p_done; m_lvl = p_lvl; m_algo = p_algo;
      if (p_kill) prev_v = 0;
      p_valid = 0;
    end
    iss_v   = (m_scan >= 0) && (cyc >= m_scan) && (cyc < m_scan + NPIX);
    iss_idx = cyc - m_scan;
    iss_src = 0;
    iss_oor = 1;
    if (iss_v) map_pix(iss_idx, m_lvl, iss_src, iss_oor);
    if (cmp_en) begin
      exp_v = {18'd0, model_busy(cyc), (cyc == m_done), 3'(m_lvl), prev_v,
               prev_v ? ADDR_W'(prev_idx) : ADDR_W'(0), prev_v ? prev_data : PIX_W'(0),
               iss_v ? ADDR_W'(iss_src) : ADDR_W'(0), m_algo};
      act_v = {18'd0, busy, controller_done, controller_zoom_level, fb_wren,
               prev_v ? fb_wraddress : ADDR_W'(0), prev_v ? fb_data : PIX_W'(0),
               src_rdaddress, algo_latched};
      check("cycle_outputs", act_v, exp_v);
    end
    prev_v    = iss_v;
    prev_idx  = iss_idx;
    prev_data = iss_oor ? PIX_W'(0) : mem[iss_src];
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic cmd(input bit rst, input bit ret, input bit zin, input bit zout, input logic [1:0] alg);
    int  a, nl;
    bit  idle, start;
    @(posedge clk); #1;
    a = cyc;
    cmd_reset_pulse = rst; cmd_return_pulse = ret;
    cmd_zoom_in_pulse = zin; cmd_zoom_out_pulse = zout;
    cmd_algorithm_select = alg;
    idle  = !model_busy(a) && (a != m_done);
    start = 0;
    nl    = m_lvl;
    p_at = a + 1; p_kill = 0;
    p_scan = m_scan; p_done = m_done; p_lvl = m_lvl; p_algo = m_algo;
    if (rst) begin
      start = 1; nl = 2;
    end else if (idle && (ret || zin || zout)) begin
      if (cmd_multiple_sw_error || cmd_no_sw_error) p_done = a + 1;
      else if (ret) begin start = 1; nl = 2; end
      else if (zin) begin
        if (m_lvl == 4) p_done = a + 1;
        else begin start = 1; nl = m_lvl + 1; end
      end else begin
        if (m_lvl == 0) p_done = a + 1;
        else begin start = 1; nl = m_lvl - 1; end
      end
    end
    if (start) begin
      p_scan = a + 1; p_done = a + 2 + NPIX; p_lvl = nl; p_algo = alg;
    end
    p_valid = 1;
    last_a  = a;
    @(posedge clk); #1;
    cmd_reset_pulse = 0; cmd_return_pulse = 0;
    cmd_zoom_in_pulse = 0; cmd_zoom_out_pulse = 0;
    cmd_algorithm_select = 2'd0;
  endtask

  task automatic por_pulse();
    @(posedge clk); #1;
    POWER_ON_RESET = 1;
    p_at = cyc + 1; p_kill = 1;
    p_scan = -1; p_done = -1; p_lvl = 2; p_algo = 2'd0;
    p_valid = 1;
    @(posedge clk); #1;
    POWER_ON_RESET = 0;
  endtask

  task automatic wait_done(input int a, input int exp_lat, input string name);
    int lat;
    lat = -1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (controller_done) begin
        lat = cyc - a;
        break;
      end
    end
    check(name, 64'(lat), 64'(exp_lat));
  endtask

  // ---------------- directed sequence ----------------
  int a0, a, w0, d0;

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      mem[i] = PIX_W'((i * 7) % 251 + 1);
      fb[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    POWER_ON_RESET = 0;
    cmp_en = 1;
    @(negedge clk);
    check("reset_level", 64'(controller_zoom_level), 64'd2);
    check("reset_outputs", {busy, controller_done, fb_wren, src_rdaddress, fb_wraddress,
                            fb_data, algo_latched, state_dbg}, 64'd0);

    // error flags block zoom commands
    cmd_no_sw_error = 1;
    w0 = wren_cnt;
    cmd(0, 0, 1, 0, 2'd1);
    wait_done(last_a, 1, "no_sw_error_done_latency");
    settle();
    check("no_sw_error_level", 64'(controller_zoom_level), 64'd2);
    check("no_sw_error_writes", 64'(wren_cnt - w0), 64'd0);
    cmd_no_sw_error = 0;
    cmd_multiple_sw_error = 1;
    w0 = wren_cnt;
    cmd(0, 0, 1, 0, 2'd1);
    wait_done(last_a, 1, "multi_sw_error_done_latency");
    settle();
    check("multi_sw_error_level", 64'(controller_zoom_level), 64'd2);
    check("multi_sw_error_writes", 64'(wren_cnt - w0), 64'd0);
    cmd_multiple_sw_error = 0;

    // return, then software reset at cycle 500 restarts the scan at level 2
    cmd(0, 1, 0, 0, 2'd3);
    a0 = last_a;
    repeat (498) @(posedge clk);
    cmd(1, 0, 0, 0, 2'd2);
    a = last_a;
    @(negedge clk); #1;
    check("restart_first_addr", 64'(src_rdaddress), 64'd0);
    check("restart_level", 64'(controller_zoom_level), 64'd2);
    check("restart_algo", 64'(algo_latched), 64'd2);
    w0 = wren_cnt;
    wait_done(a, 19202, "reset_done_latency");
    settle();
    check("reset_write_count", 64'(wren_cnt - w0), 64'd19200);
    check("reset_pixel_9680", 64'(fb[9680]), 64'(mem[9680]));

    // zoom in to level 3
    w0 = wren_cnt;
    cmd(0, 0, 1, 0, 2'd1);
    wait_done(last_a, 19202, "zoom3_done_latency");
    settle();
    check("zoom3_level", 64'(controller_zoom_level), 64'd3);
    check("zoom3_algo", 64'(algo_latched), 64'd1);
    check("zoom3_write_count", 64'(wren_cnt - w0), 64'd19200);
    check("zoom3_pixel_0_0", 64'(fb[0]), 64'(mem[4840]));
    check("zoom3_pixel_159_119", 64'(fb[19199]), 64'(mem[89 * 160 + 119]));

    // zoom in to level 4; zoom_out at cycle 500 must be ignored
    d0 = done_cnt;
    cmd(0, 0, 1, 0, 2'd0);
    a0 = last_a;
    repeat (498) @(posedge clk);
    cmd(0, 0, 0, 1, 2'd3);
    wait_done(a0, 19202, "zoom4_done_latency");
    repeat (5) settle();
    check("zoom4_single_done", 64'(done_cnt - d0), 64'd1);
    check("zoom4_level", 64'(controller_zoom_level), 64'd4);

    // saturation at the top level
    w0 = wren_cnt;
    cmd(0, 0, 1, 0, 2'd2);
    wait_done(last_a, 1, "sat_done_latency");
    settle();
    check("sat_level", 64'(controller_zoom_level), 64'd4);
    check("sat_writes", 64'(wren_cnt - w0), 64'd0);

    // power-on reset back to unity, then zoom out twice
    por_pulse();
    check("por_level", 64'(controller_zoom_level), 64'd2);
    cmd(0, 0, 0, 1, 2'd0);
    wait_done(last_a, 19202, "zoom1_done_latency");
    settle();
    check("zoom1_level", 64'(controller_zoom_level), 64'd1);
    fb[0] = 8'hAA; fb[9680] = 8'h00; fb[9681] = 8'h00;
    cmd(0, 0, 0, 1, 2'd3);
    repeat (9688) settle();
    check("zoom0_level", 64'(controller_zoom_level), 64'd0);
    check("zoom0_pixel_0_0", 64'(fb[0]), 64'd0);
    check("zoom0_pixel_80_60", 64'(fb[9680]), 64'(mem[9680]));
    check("zoom0_pixel_81_60", 64'(fb[9681]), 64'(mem[9684]));

    // power-on reset mid-scan aborts without a done pulse
    d0 = done_cnt;
    por_pulse();
    @(negedge clk);
    check("por_abort_quiet", 64'({fb_wren, busy}), 64'd0);
    repeat (200) settle();
    check("por_abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("por_abort_level", 64'(controller_zoom_level), 64'd2);

    settle();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
